// File: rtl/eq2_chk_pkg.sv
// Shared types and constants for the eq2 response checker.
package eq2_chk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_e;

  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam int unsigned CNT_W_MAX     = 32;

  // All-ones value of a w-bit counter, right-aligned in a CNT_W_MAX-bit word.
  function automatic logic [CNT_W_MAX-1:0] cnt_max(input int unsigned w);
    logic [CNT_W_MAX-1:0] ones;
    ones = '1;
    return ones >> (CNT_W_MAX - w);
  endfunction

endpackage

// File: rtl/eq2_chk_delay.sv
// LAT-deep valid+payload delay line with synchronous flush; LAT=0 is a pass-through.
// pending reports valid entries that will still be in flight after the current edge.
module eq2_chk_delay #(
  parameter int unsigned LAT = 1,
  parameter int unsigned W   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         pending
);

  generate
    if (LAT == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst_n};
      assign out_valid = in_valid && !flush;
      assign out_data  = in_data;
      assign pending   = 1'b0;
    end else begin : g_pipe
      logic [LAT-1:0]        vld;
      logic [LAT-1:0][W-1:0] dat;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= '0;
          dat <= '0;
        end else begin
          vld[0] <= in_valid && !flush;
          dat[0] <= in_data;
          for (int unsigned i = 1; i < LAT; i++) begin
            vld[i] <= vld[i-1] && !flush;
            dat[i] <= dat[i-1];
          end
        end
      end

      assign out_valid = vld[LAT-1];
      assign out_data  = dat[LAT-1];

      // The output stage is compared this cycle, so only earlier stages count as pending.
      if (LAT > 1) begin : g_pend
        assign pending = |vld[LAT-2:0];
      end else begin : g_nopend
        assign pending = 1'b0;
      end
    end
  endgenerate

endmodule

// File: rtl/eq2_resp_checker.sv
// Response checker for the 2-bit equality comparator: latency-aligned expected vs DUT aeqb.
// Optional macro EQ2_CHK_FAIL_CAPTURE_EN adds first_fail_a/_b capture of the first mismatch.
module eq2_resp_checker
  import eq2_chk_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned LAT   = 1,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             vec_last,
  input  logic [WIDTH-1:0] vec_a,
  input  logic [WIDTH-1:0] vec_b,
  input  logic             dut_aeqb,
  output logic             busy,
  output logic             done,
  output logic             any_fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
`ifdef EQ2_CHK_FAIL_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_b
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
`ifdef EQ2_CHK_FAIL_CAPTURE_EN
  localparam int unsigned PW = 1 + 2 * WIDTH;
`else
  localparam int unsigned PW = 1;
`endif

  chk_state_e state, state_nxt;

  logic          accept;
  logic          exp_bit;
  logic [PW-1:0] d_in;
  logic          d_out_valid;
  logic [PW-1:0] d_out;
  logic          d_pending;
  logic          cmp_valid;
  logic          cmp_match;
  logic          cmp_miss;

  assign accept  = (state == RUN) && vec_valid && !start;
  assign exp_bit = (vec_a == vec_b);

`ifdef EQ2_CHK_FAIL_CAPTURE_EN
  assign d_in = {exp_bit, vec_a, vec_b};
`else
  assign d_in = exp_bit;
`endif

  eq2_chk_delay #(
    .LAT (LAT),
    .W   (PW)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (start),
    .in_valid  (accept),
    .in_data   (d_in),
    .out_valid (d_out_valid),
    .out_data  (d_out),
    .pending   (d_pending)
  );

  // A start in the same cycle discards whatever emerges from the delay line.
  assign cmp_valid = d_out_valid && !start;
  assign cmp_match = cmp_valid && (dut_aeqb == d_out[PW-1]);
  assign cmp_miss  = cmp_valid && (dut_aeqb != d_out[PW-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (start) begin
          state_nxt = RUN;
        end else if (vec_valid && vec_last) begin
          state_nxt = (LAT == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (start) begin
          state_nxt = RUN;
        end else if (!d_pending) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      any_fail <= 1'b0;
    end else if (start) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      any_fail <= 1'b0;
    end else begin
      if (cmp_match && (pass_cnt != CNT_MAX)) pass_cnt <= pass_cnt + 1'b1;
      if (cmp_miss && (fail_cnt != CNT_MAX))  fail_cnt <= fail_cnt + 1'b1;
      if (cmp_miss)                           any_fail <= 1'b1;
    end
  end

`ifdef EQ2_CHK_FAIL_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_a <= '0;
      first_fail_b <= '0;
    end else if (start) begin
      first_fail_a <= '0;
      first_fail_b <= '0;
    end else if (cmp_miss && !any_fail) begin
      first_fail_a <= d_out[2*WIDTH-1:WIDTH];
      first_fail_b <= d_out[WIDTH-1:0];
    end
  end
`endif

endmodule
